cond_flag_unit: RTL and testbench
=================================

# cond_flag_unit

Consumer side of the ALU flag interface. It holds the architectural NZCV flag register written from `ALUFlags` and evaluates the 4-bit ARM condition field against the held flags. It gates the instruction's PC, register and memory write strobes, and keeps a single-level shadow copy of the flags for interrupt entry and return. It sits between the decoder and the datapath write enables in the single-cycle core.

## Interface
Parameters:
- none; flag order is fixed as {N, Z, C, V}, bit 3 down to bit 0, matching `ALUFlags`.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Cond`  in  4  instruction condition field, bits [31:28].
- `ALUFlags`  in  4  {N,Z,C,V} from the ALU for the current instruction.
- `FlagW`  in  2  [1] = write N,Z; [0] = write C,V (from the decoder).
- `PCS`, `RegW`, `MemW`  in  1 each  unconditioned write requests from the decoder.
- `NoWrite`  in  1  compare-type op: suppress the register write even when executed.
- `IrqEntry`  in  1  one-cycle pulse: take an interrupt this cycle.
- `IrqReturn`  in  1  one-cycle pulse: return from the interrupt this cycle.
- `PCSrc`, `RegWrite`, `MemWrite`  out  1 each  gated write strobes.
- `CondEx`  out  1  the current instruction executes.
- `Flags`  out  4  architectural flag register.
- `SavedFlags`  out  4  shadow flag register.
- `InIrq`  out  1  the shadow register is occupied.

## Operation
Condition evaluation is combinational on the registered `Flags`, never on `ALUFlags`:
- 0000 EQ: Z. 0001 NE: !Z.
- 0010 CS: C. 0011 CC: !C.
- 0100 MI: N. 0101 PL: !N.
- 0110 VS: V. 0111 VC: !V.
- 1000 HI: C & !Z. 1001 LS: !C | Z.
- 1010 GE: N==V. 1011 LT: N!=V.
- 1100 GT: !Z & (N==V). 1101 LE: Z | (N!=V).
- 1110 AL: 1. 1111: 0 (reserved, never executes).

Squash:
- `squash` = accepted `IrqEntry` or accepted `IrqReturn`.
- `CondEx` = condition true & !`squash`.

Gated strobes:
- `PCSrc` = `PCS` & `CondEx`.
- `RegWrite` = `RegW` & `CondEx` & !`NoWrite`.
- `MemWrite` = `MemW` & `CondEx`.

Flag writes, at the clock edge:
- `Flags[3:2]` <= `ALUFlags[3:2]` if `FlagW[1]` & `CondEx`.
- `Flags[1:0]` <= `ALUFlags[1:0]` if `FlagW[0]` & `CondEx`.
- Halves update independently; an unselected half holds.

Interrupt FSM, two states:
- IDLE (`InIrq`=0):
  - `IrqEntry` accepted: `SavedFlags` <= `Flags` (pre-update value), `Flags` hold, go to IN_IRQ.
  - `IrqReturn` ignored, no squash.
- IN_IRQ (`InIrq`=1):
  - `IrqReturn` accepted: `Flags` <= `SavedFlags`, `SavedFlags` hold, go to IDLE.
  - `IrqEntry` ignored, no squash; the shadow is single-level and nesting is not supported.
- `IrqEntry` and `IrqReturn` together:
  - In IDLE, entry is accepted.
  - In IN_IRQ, return is accepted.
  - Exactly one event is accepted, so the instruction is squashed once.
- An accepted event has priority over the instruction's flag write. The squash forces `CondEx`=0, so no flag write occurs that cycle.

## Timing
- Reset (`reset`=0, asynchronous):
  - `Flags`=0000, `SavedFlags`=0000, state IDLE, `InIrq`=0.
  - Combinational outputs follow from these values while reset is held, e.g. Cond=EQ gives `CondEx`=0.
- Latency: `CondEx` and the strobes are zero-cycle combinational from `Cond`, the decoder inputs, the IRQ pulses and `Flags`.
  - A flag write becomes visible to the next instruction, one cycle later.
  - An instruction never sees its own `ALUFlags`.
- `SavedFlags` and `Flags` restores are visible the cycle after the accepted event.
- Reset asserted mid-interrupt: returns to IDLE immediately and clears the shadow; no restore.
- No internal pipelining; one instruction per cycle.

## Test plan
- Reset release, Cond=1110, RegW=1, NoWrite=0 -> RegWrite=1, Flags=0000. Cond=0000 -> CondEx=0.
- Cond=AL, FlagW=11, ALUFlags=0110 (Z,C) -> next cycle Flags=0110. Then Cond=EQ, PCS=1 -> PCSrc=1; Cond=HI -> CondEx=0; Cond=CS -> CondEx=1.
- Flags=0110, Cond=AL, FlagW=10, ALUFlags=1001 -> Flags=1010, C,V held. Then Cond=LT -> CondEx=1 (N=1, V=0); Cond=GE -> CondEx=0.
- Flags=0000, Cond=1110, FlagW=11, ALUFlags=1111, NoWrite=1, RegW=1 -> RegWrite=0, Flags=1111 next cycle. Then Cond=1111, MemW=1 -> MemWrite=0.
- Interrupt sequence:
  - Flags=1010, IrqEntry with Cond=AL, FlagW=11, ALUFlags=0101 -> CondEx=0; next cycle SavedFlags=1010, Flags=1010, InIrq=1.
  - Handler writes Flags=0100.
  - IrqEntry again -> ignored, no squash.
  - IrqReturn -> next cycle Flags=1010, InIrq=0.
- Edge cases:
  - IrqEntry and IrqReturn together in IDLE -> entry taken, InIrq=1.
  - Async reset pulse while InIrq=1 -> all registers 0000, InIrq=0, with no clock edge required.

Source files
------------

// File: rtl/cond_flag_unit.sv
// Condition/flag unit: holds NZCV, evaluates the ARM condition field against it,
// gates the decoder write strobes and keeps a single-level interrupt shadow of the flags.
module cond_flag_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       IrqEntry,
  input  logic       IrqReturn,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags,
  output logic [3:0] SavedFlags,
  output logic       InIrq
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_IRQ = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic [3:0] saved_q, saved_d;
  logic       cond_true_s;
  logic       accept_entry_s;
  logic       accept_return_s;
  logic       cond_ex_s;

  // Condition decode against the registered flags {N,Z,C,V}.
  always_comb begin
    cond_true_s = 1'b0;
    case (Cond)
      4'b0000: cond_true_s = flags_q[2];
      4'b0001: cond_true_s = ~flags_q[2];
      4'b0010: cond_true_s = flags_q[1];
      4'b0011: cond_true_s = ~flags_q[1];
      4'b0100: cond_true_s = flags_q[3];
      4'b0101: cond_true_s = ~flags_q[3];
      4'b0110: cond_true_s = flags_q[0];
      4'b0111: cond_true_s = ~flags_q[0];
      4'b1000: cond_true_s = flags_q[1] & ~flags_q[2];
      4'b1001: cond_true_s = ~flags_q[1] | flags_q[2];
      4'b1010: cond_true_s = (flags_q[3] == flags_q[0]);
      4'b1011: cond_true_s = (flags_q[3] != flags_q[0]);
      4'b1100: cond_true_s = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_true_s = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_true_s = 1'b1;
      default: cond_true_s = 1'b0;
    endcase
  end

  // Only the event meaningful in the current state is accepted, so at most one squash.
  always_comb begin
    accept_entry_s  = (state_q == ST_IDLE)   & IrqEntry;
    accept_return_s = (state_q == ST_IN_IRQ) & IrqReturn;
    cond_ex_s       = cond_true_s & ~(accept_entry_s | accept_return_s);
  end

  // Interrupt FSM and flag next-state; a squashed cycle never writes flags.
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    saved_d = saved_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_entry_s) begin
          saved_d = flags_q;
          state_d = ST_IN_IRQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IN_IRQ: begin
        if (accept_return_s) begin
          flags_d = saved_q;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_IN_IRQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (cond_ex_s & FlagW[1]) begin
      flags_d[3:2] = ALUFlags[3:2];
    end else begin
      flags_d[3:2] = flags_d[3:2];
    end
    if (cond_ex_s & FlagW[0]) begin
      flags_d[1:0] = ALUFlags[1:0];
    end else begin
      flags_d[1:0] = flags_d[1:0];
    end
  end

  // State registers; reset mid-interrupt drops the shadow without restoring it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      flags_q <= 4'b0000;
      saved_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      saved_q <= saved_d;
    end
  end

  // Output strobes are combinational so the current instruction is gated in-cycle.
  always_comb begin
    CondEx     = cond_ex_s;
    PCSrc      = PCS & cond_ex_s;
    RegWrite   = RegW & cond_ex_s & ~NoWrite;
    MemWrite   = MemW & cond_ex_s;
    Flags      = flags_q;
    SavedFlags = saved_q;
    InIrq      = (state_q == ST_IN_IRQ);
  end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Self-checking bench for cond_flag_unit: directed plan steps plus randomized cycles
// compared against a behavioural model of the flag/interrupt rules.
module tb_cond_flag_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite, IrqEntry, IrqReturn;
  logic       PCSrc, RegWrite, MemWrite, CondEx, InIrq;
  logic [3:0] Flags, SavedFlags;

  int tests = 0;
  int fails = 0;

  logic [3:0] m_flags, m_saved;
  logic       m_irq;

  cond_flag_unit dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .IrqEntry(IrqEntry), .IrqReturn(IrqReturn),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
    .Flags(Flags), .SavedFlags(SavedFlags), .InIrq(InIrq)
  );

  always #5 clk = ~clk;

  // Odd codes are the negation of the even code below them; 1111 never executes.
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  function automatic logic model_ex();
    logic sq;
    sq = (!m_irq && IrqEntry) || (m_irq && IrqReturn);
    return cond_model(Cond, m_flags) && !sq;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw,
                       input logic pcs, input logic rw, input logic mw, input logic nw,
                       input logic ie, input logic ir);
    logic ex;
    Cond = c; ALUFlags = af; FlagW = fw; PCS = pcs; RegW = rw; MemW = mw;
    NoWrite = nw; IrqEntry = ie; IrqReturn = ir;
    #1;
    ex = model_ex();
    chk("model_condex", {3'b000, CondEx}, {3'b000, ex});
    chk("model_pcsrc", {3'b000, PCSrc}, {3'b000, pcs && ex});
    chk("model_regwrite", {3'b000, RegWrite}, {3'b000, rw && ex && !nw});
    chk("model_memwrite", {3'b000, MemWrite}, {3'b000, mw && ex});
  endtask

  task automatic tick();
    logic ex;
    @(posedge clk);
    ex = model_ex();
    if (!m_irq && IrqEntry) begin
      m_saved = m_flags;
      m_irq   = 1'b1;
    end else if (m_irq && IrqReturn) begin
      m_flags = m_saved;
      m_irq   = 1'b0;
    end else if (ex) begin
      if (FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
      if (FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
    end
    #1;
    chk("model_flags", Flags, m_flags);
    chk("model_saved", SavedFlags, m_saved);
    chk("model_inirq", {3'b000, InIrq}, {3'b000, m_irq});
  endtask

  initial begin
    reset = 1'b0;
    m_flags = 4'h0; m_saved = 4'h0; m_irq = 1'b0;
    Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00; PCS = 1'b0; RegW = 1'b0;
    MemW = 1'b0; NoWrite = 1'b0; IrqEntry = 1'b0; IrqReturn = 1'b0;
    #2;
    chk("rst_condex_eq", {3'b000, CondEx}, 4'h0);
    chk("rst_flags", Flags, 4'h0);
    chk("rst_saved", SavedFlags, 4'h0);
    chk("rst_inirq", {3'b000, InIrq}, 4'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    drive(4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("al_regwrite", {3'b000, RegWrite}, 4'h1);
    chk("al_flags0", Flags, 4'h0);
    drive(4'h0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("eq_z0", {3'b000, CondEx}, 4'h0);

    drive(4'hE, 4'h6, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("write_zc", Flags, 4'h6);
    drive(4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("eq_pcsrc", {3'b000, PCSrc}, 4'h1);
    drive(4'h8, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("hi_false", {3'b000, CondEx}, 4'h0);
    drive(4'h2, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("cs_true", {3'b000, CondEx}, 4'h1);

    drive(4'hE, 4'h9, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("half_nz", Flags, 4'hA);
    drive(4'hB, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lt_true", {3'b000, CondEx}, 4'h1);
    drive(4'hA, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ge_false", {3'b000, CondEx}, 4'h0);

    drive(4'hE, 4'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(4'hE, 4'hF, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("nowrite", {3'b000, RegWrite}, 4'h0);
    tick();
    chk("cmp_flags", Flags, 4'hF);
    drive(4'hF, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("nv_memwrite", {3'b000, MemWrite}, 4'h0);

    drive(4'hE, 4'hA, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(4'hE, 4'h5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("entry_squash", {3'b000, CondEx}, 4'h0);
    tick();
    chk("entry_saved", SavedFlags, 4'hA);
    chk("entry_flags", Flags, 4'hA);
    chk("entry_inirq", {3'b000, InIrq}, 4'h1);
    drive(4'hE, 4'h4, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("handler_flags", Flags, 4'h4);
    drive(4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("nested_no_squash", {3'b000, RegWrite}, 4'h1);
    tick();
    chk("nested_saved", SavedFlags, 4'hA);
    drive(4'hE, 4'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("return_squash", {3'b000, CondEx}, 4'h0);
    tick();
    chk("return_flags", Flags, 4'hA);
    chk("return_inirq", {3'b000, InIrq}, 4'h0);

    drive(4'hE, 4'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("both_idle_squash", {3'b000, CondEx}, 4'h0);
    tick();
    chk("both_idle_entry", {3'b000, InIrq}, 4'h1);
    drive(4'hE, 4'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("both_irq_return", {3'b000, InIrq}, 4'h0);

    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 2'($urandom_range(3, 0)),
            1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
            1'($urandom_range(1, 0)), 1'($urandom_range(7, 0) == 0),
            1'($urandom_range(5, 0) == 0));
      tick();
    end

    drive(4'hE, 4'h7, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("pre_rst_inirq", {3'b000, InIrq}, 4'h1);
    drive(4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("async_flags", Flags, 4'h0);
    chk("async_saved", SavedFlags, 4'h0);
    chk("async_inirq", {3'b000, InIrq}, 4'h0);
    #2;
    reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
